gp_register_bank: RTL and testbench

Parametrised successor to the single general-purpose register: a bank of 2**SEL_WIDTH registers of WIDTH bits with one load port, two independent tri-state read ports and a per-cycle increment/decrement unit with wrap-around carry. It sits between the CPU data bus and the ALU operand buses. It replaces discrete per-register instances for the GP/SP/PC set.

---
 rtl/gp_register_bank.sv | 55 +++++
 tb/tb_gp_register_bank.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/gp_register_bank.sv
// gp_register_bank: bank of 2**SEL_WIDTH registers with one load port, two tri-state read ports
// and an increment/decrement unit reporting wrap-around carry and illegal-request conflicts.
module gp_register_bank #(
    parameter int WIDTH     = 16,
    parameter int SEL_WIDTH = 3
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 notLoad,
    input  logic [SEL_WIDTH-1:0] loadSel,
    input  logic [WIDTH-1:0]     dataIn,
    input  logic                 notOEA,
    input  logic [SEL_WIDTH-1:0] oeSelA,
    output tri   [WIDTH-1:0]     busA,
    input  logic                 notOEB,
    input  logic [SEL_WIDTH-1:0] oeSelB,
    output tri   [WIDTH-1:0]     busB,
    input  logic                 notInc,
    input  logic                 notDec,
    input  logic [SEL_WIDTH-1:0] incSel,
    output logic                 carry,
    output logic                 conflict
);
    localparam int N = 2 ** SEL_WIDTH;

    logic [WIDTH-1:0] regs [N];
    logic [WIDTH-1:0] cur;
    logic             inc_req, dec_req, both_req, load_hit, step;

    assign inc_req  = !notInc && notDec;
    assign dec_req  = notInc && !notDec;
    assign both_req = !notInc && !notDec;
    assign load_hit = !notLoad && (loadSel == incSel);
    // a load to the same register pre-empts the inc/dec entirely
    assign step     = (inc_req || dec_req) && !load_hit;
    assign cur      = regs[incSel];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N; i++) regs[i] <= '0;
            carry    <= 1'b0;
            conflict <= 1'b0;
        end else begin
            if (step) begin
                regs[incSel] <= inc_req ? cur + WIDTH'(1) : cur - WIDTH'(1);
                carry        <= inc_req ? &cur : ~|cur;
            end
            if (!notLoad) regs[loadSel] <= dataIn;
            conflict <= both_req || (load_hit && (inc_req || dec_req));
        end
    end

    assign busA = notOEA ? {WIDTH{1'bz}} : regs[oeSelA];
    assign busB = notOEB ? {WIDTH{1'bz}} : regs[oeSelB];
endmodule

// File: tb/tb_gp_register_bank.sv
// tb_gp_register_bank: directed scenarios plus randomized traffic checked against an array model.
module tb_gp_register_bank;
    logic        clock = 1'b0;
    logic        reset, notLoad, notOEA, notOEB, notInc, notDec;
    logic [2:0]  loadSel, oeSelA, oeSelB, incSel;
    logic [15:0] din, ext_a, ext_b;
    logic        bus_load, ext_a_en, ext_b_en;
    tri   [15:0] busA, busB;
    wire  [15:0] dataIn;
    wire         carry, conflict;

    int checks = 0;
    int errors = 0;

    logic [15:0] m [8];
    logic        mc, mk;

    assign busA   = ext_a_en ? ext_a : 'z;
    assign busB   = ext_b_en ? ext_b : 'z;
    assign dataIn = bus_load ? busA : din;

    gp_register_bank #(.WIDTH(16), .SEL_WIDTH(3)) dut (
        .clock(clock), .reset(reset), .notLoad(notLoad), .loadSel(loadSel), .dataIn(dataIn),
        .notOEA(notOEA), .oeSelA(oeSelA), .busA(busA),
        .notOEB(notOEB), .oeSelB(oeSelB), .busB(busB),
        .notInc(notInc), .notDec(notDec), .incSel(incSel),
        .carry(carry), .conflict(conflict)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle();
        notLoad = 1; notInc = 1; notDec = 1;
        bus_load = 0; ext_a_en = 0; ext_b_en = 0;
    endtask

    // advance one rising edge, updating the model from the request rules
    task automatic tick();
        logic [15:0] old;
        logic        wi, wd;
        old = m[incSel];
        wi  = !notInc;
        wd  = !notDec;
        if (!reset) begin
            if (!notLoad) m[loadSel] = dataIn;
            if (wi && wd) mk = 1;
            else if (wi || wd) begin
                if (!notLoad && loadSel == incSel) mk = 1;
                else begin
                    m[incSel] = wi ? old + 16'd1 : old - 16'd1;
                    mc = wi ? (old == 16'hFFFF) : (old == 16'h0000);
                    mk = 0;
                end
            end else mk = 0;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic read_a(input logic [2:0] s, output logic [15:0] v);
        ext_a_en = 0; notOEA = 0; oeSelA = s;
        #1;
        v = busA;
    endtask

    task automatic test_reset();
        idle();
        notOEA = 1; notOEB = 1; oeSelA = 0; oeSelB = 0;
        loadSel = 0; incSel = 0; din = 0;
        reset = 1;
        for (int i = 0; i < 8; i++) m[i] = 0;
        mc = 0; mk = 0;
        @(posedge clock); @(posedge clock);
        @(negedge clock);
        reset = 0;
        ext_a_en = 1; ext_a = 16'h5A3C; ext_b_en = 1; ext_b = 16'hC3A5;
        #1;
        checks++; if (busA !== 16'h5A3C) begin errors++; $display("FAIL reset_hiz_a got %h want %h", busA, 16'h5A3C); end
        checks++; if (busB !== 16'hC3A5) begin errors++; $display("FAIL reset_hiz_b got %h want %h", busB, 16'hC3A5); end
        ext_a_en = 0; ext_b_en = 0;
        notOEA = 0; oeSelA = 0;
        #1;
        checks++; if (busA !== 16'h0000) begin errors++; $display("FAIL reset_reg0 got %h want 0000", busA); end
        checks++; if (carry !== 1'b0 || conflict !== 1'b0) begin errors++; $display("FAIL reset_flags got %b%b want 00", carry, conflict); end
    endtask

    task automatic test_load_from_bus();
        notOEA = 1; notOEB = 0; oeSelB = 2;
        ext_a_en = 1; ext_a = 16'hBEEF; bus_load = 1;
        notLoad = 0; loadSel = 2;
        #1;
        checks++; if (busB !== 16'h0000) begin errors++; $display("FAIL load_no_bypass got %h want 0000", busB); end
        tick();
        idle();
        notOEA = 0; oeSelA = 2;
        #1;
        checks++; if (busA !== 16'hBEEF) begin errors++; $display("FAIL load_read_a got %h want BEEF", busA); end
        checks++; if (busB !== 16'hBEEF) begin errors++; $display("FAIL load_read_b got %h want BEEF", busB); end
    endtask

    task automatic test_wrap();
        logic [15:0] v;
        logic        want_inc [4] = '{1, 1, 0, 0};
        logic [15:0] want_v   [4] = '{16'hFFFF, 16'h0000, 16'hFFFF, 16'hFFFE};
        logic        want_c   [4] = '{0, 1, 1, 0};
        idle();
        notLoad = 0; loadSel = 7; din = 16'hFFFE;
        tick();
        idle();
        incSel = 7;
        for (int i = 0; i < 4; i++) begin
            notInc = !want_inc[i]; notDec = want_inc[i];
            tick();
            idle();
            read_a(7, v);
            checks++; if (v !== want_v[i] || carry !== want_c[i])
                begin errors++; $display("FAIL wrap_step%0d got %h c=%b want %h c=%b", i, v, carry, want_v[i], want_c[i]); end
        end
    endtask

    task automatic test_conflicts();
        logic [15:0] v;
        logic        c0;
        idle();
        notLoad = 0; loadSel = 4; din = 16'h0010;
        tick();
        notLoad = 0; loadSel = 3; din = 16'h1234; notInc = 0; incSel = 3;
        tick();
        idle();
        read_a(3, v);
        checks++; if (v !== 16'h1234 || conflict !== 1'b1) begin errors++; $display("FAIL same_reg got %h k=%b want 1234 k=1", v, conflict); end
        tick();
        checks++; if (conflict !== 1'b0) begin errors++; $display("FAIL conflict_clear got %b want 0", conflict); end
        notLoad = 0; loadSel = 3; din = 16'h5555; notInc = 0; incSel = 4;
        tick();
        idle();
        read_a(4, v);
        checks++; if (v !== 16'h0011 || conflict !== 1'b0) begin errors++; $display("FAIL diff_reg got %h k=%b want 0011 k=0", v, conflict); end
        read_a(3, v);
        checks++; if (v !== 16'h5555) begin errors++; $display("FAIL diff_reg_load got %h want 5555", v); end
        notLoad = 0; loadSel = 1; din = 16'h0005;
        tick();
        idle();
        c0 = carry;
        notInc = 0; notDec = 0; incSel = 1;
        tick();
        idle();
        read_a(1, v);
        checks++; if (v !== 16'h0005 || conflict !== 1'b1 || carry !== c0)
            begin errors++; $display("FAIL inc_dec_both got %h k=%b c=%b want 0005 k=1 c=%b", v, conflict, carry, c0); end
    endtask

    task automatic test_async_reset();
        logic [15:0] v;
        idle();
        notLoad = 0; loadSel = 5; din = 16'hA5A5;
        tick();
        idle();
        notDec = 0; incSel = 0;
        tick();
        idle();
        notInc = 0; notDec = 0;
        tick();
        idle();
        checks++; if (carry !== 1'b1 || conflict !== 1'b1) begin errors++; $display("FAIL pre_reset_flags got %b%b want 11", carry, conflict); end
        read_a(5, v);
        checks++; if (v !== 16'hA5A5) begin errors++; $display("FAIL pre_reset_reg5 got %h want A5A5", v); end
        #2;
        reset = 1;
        #1;
        checks++; if (busA !== 16'h0000) begin errors++; $display("FAIL async_reset_bus got %h want 0000", busA); end
        checks++; if (carry !== 1'b0 || conflict !== 1'b0) begin errors++; $display("FAIL async_reset_flags got %b%b want 00", carry, conflict); end
        for (int i = 0; i < 8; i++) m[i] = 0;
        mc = 0; mk = 0;
        notLoad = 0; loadSel = 5; din = 16'h1111; notInc = 0; incSel = 5;
        tick();
        idle();
        checks++; if (busA !== 16'h0000 || carry !== 1'b0 || conflict !== 1'b0)
            begin errors++; $display("FAIL load_in_reset got %h %b%b want 0000 00", busA, carry, conflict); end
        @(negedge clock);
        reset = 0;
    endtask

    task automatic test_random();
        logic [15:0] ea, eb;
        idle();
        for (int n = 0; n < 400; n++) begin
            notLoad = $urandom_range(0, 2) != 0;
            loadSel = 3'($urandom);
            din     = $urandom_range(0, 3) == 0 ? 16'hFFFF : 16'($urandom);
            notInc  = $urandom_range(0, 2) == 0;
            notDec  = $urandom_range(0, 2) == 0;
            incSel  = 3'($urandom_range(0, 7));
            notOEA  = $urandom_range(0, 3) == 0;
            notOEB  = $urandom_range(0, 3) == 0;
            oeSelA  = 3'($urandom);
            oeSelB  = 3'($urandom);
            ext_a_en = notOEA; ext_a = 16'($urandom);
            ext_b_en = notOEB; ext_b = 16'($urandom);
            #2;
            ea = notOEA ? ext_a : m[oeSelA];
            eb = notOEB ? ext_b : m[oeSelB];
            checks++; if (busA !== ea) begin errors++; $display("FAIL rand_a[%0d] sel=%0d oe_n=%b got %h want %h", n, oeSelA, notOEA, busA, ea); end
            checks++; if (busB !== eb) begin errors++; $display("FAIL rand_b[%0d] sel=%0d oe_n=%b got %h want %h", n, oeSelB, notOEB, busB, eb); end
            tick();
            checks++; if (carry !== mc || conflict !== mk)
                begin errors++; $display("FAIL rand_flags[%0d] got c=%b k=%b want c=%b k=%b", n, carry, conflict, mc, mk); end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_load_from_bus();
        test_wrap();
        test_conflicts();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
